// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read and write pointer logic:
//   - default FIFO geometry (DEPTH / PTR_SZ)
//   - read-side FSM state encodings
//   - binary <-> Gray conversion helpers
// The helpers work on a fixed 16-bit container. Callers zero-extend narrower
// pointers and truncate the result. The leading zeros do not disturb the
// low-order bits in either direction.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DEPTH_DEF  = 3;
    localparam int FIFO_PTR_SZ_DEF = 2;
    localparam int GRAY_MAX_W      = 16;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_AVAIL = 2'b01,
        S_READ  = 2'b10
    } rd_state_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational Gray-to-binary decoder for a synchronized FIFO pointer.
// Parameters:
//   PTR_SZ  pointer width in bits (at most 16)
// Ports:
//   gray_i  Gray-coded pointer
//   bin_o   binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int PTR_SZ = FIFO_PTR_SZ_DEF
) (
    input  logic [PTR_SZ-1:0] gray_i,
    output logic [PTR_SZ-1:0] bin_o
);

    assign bin_o = PTR_SZ'(gray2bin(GRAY_MAX_W'(gray_i)));

endmodule

// File: rtl/fifo_read_logic.sv
// -----------------------------------------------------------------------------
// fifo_read_logic
// Read-side pointer and flag logic of an asynchronous FIFO. A three-state Moore
// FSM (S_EMPTY / S_AVAIL / S_READ) issues one memory read strobe per accepted
// request. It advances a binary read address that wraps at DEPTH-1. It also
// publishes the Gray form of that address for the write-side synchronizer.
//
// Parameters:
//   DEPTH       number of FIFO memory slots
//   PTR_SZ      address width, DEPTH <= 2**PTR_SZ
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   rinc        read request (level)
//   rq2_waddr   write address in Gray code, already in the clk domain
//   rempty      registered empty flag (state == S_EMPTY)
//   read_en     registered memory read strobe (state == S_READ)
//   raddr       registered binary read address
//   raddr_gray  registered Gray form of raddr
//   rcount      registered occupancy (wbin - raddr) mod DEPTH; present only
//               when the macro FIFO_READ_OCCUPANCY_EN is defined
// -----------------------------------------------------------------------------
module fifo_read_logic
    import fifo_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int PTR_SZ = FIFO_PTR_SZ_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rinc,
    input  logic [PTR_SZ-1:0] rq2_waddr,
    output logic              rempty,
    output logic              read_en,
    output logic [PTR_SZ-1:0] raddr,
    output logic [PTR_SZ-1:0] raddr_gray
`ifdef FIFO_READ_OCCUPANCY_EN
    ,
    output logic [PTR_SZ-1:0] rcount
`endif
);

    localparam logic [PTR_SZ-1:0] LAST_ADDR = PTR_SZ'(DEPTH - 1);

    rd_state_e         state_q, state_d;
    logic [PTR_SZ-1:0] raddr_q, raddr_d;
    logic [PTR_SZ-1:0] raddr_gray_q, raddr_gray_d;
    logic              rempty_q, rempty_d;
    logic              read_en_q, read_en_d;
    logic [PTR_SZ-1:0] wbin_s;
    logic [PTR_SZ-1:0] next_raddr_s;

    fifo_gray2bin #(
        .PTR_SZ (PTR_SZ)
    ) u_waddr_dec (
        .gray_i (rq2_waddr),
        .bin_o  (wbin_s)
    );

    // Address of the slot after the current one, wrapping at DEPTH-1.
    always_comb begin
        next_raddr_s = raddr_q + {{(PTR_SZ-1){1'b0}}, 1'b1};
        if (raddr_q == LAST_ADDR) begin
            next_raddr_s = {PTR_SZ{1'b0}};
        end else begin
            next_raddr_s = raddr_q + {{(PTR_SZ-1){1'b0}}, 1'b1};
        end
    end

    // Next-state, next-address and next-flag logic.
    // The flags are registered copies of the next-state decode, so they always
    // match the current state. The empty check in S_READ uses the live wbin.
    // A write landing in the same cycle as the last read therefore keeps the
    // FIFO non-empty.
    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        unique case (state_q)
            S_EMPTY: begin
                if (wbin_s != raddr_q) begin
                    state_d = S_AVAIL;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_AVAIL: begin
                if (rinc) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_AVAIL;
                end
            end
            S_READ: begin
                raddr_d = next_raddr_s;
                if (wbin_s == next_raddr_s) begin
                    state_d = S_EMPTY;
                end else if (rinc) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_AVAIL;
                end
            end
            default: begin
                state_d = S_EMPTY;
                raddr_d = {PTR_SZ{1'b0}};
            end
        endcase

        if (rst) begin
            state_d = S_EMPTY;
            raddr_d = {PTR_SZ{1'b0}};
        end else begin
            state_d = state_d;
            raddr_d = raddr_d;
        end

        raddr_gray_d = PTR_SZ'(bin2gray(GRAY_MAX_W'(raddr_d)));
        rempty_d     = (state_d == S_EMPTY);
        read_en_d    = (state_d == S_READ);
    end

    // State, address and flag registers. Reset is folded into the _d terms
    // above so that every register always loads its own next value.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        raddr_q      <= raddr_d;
        raddr_gray_q <= raddr_gray_d;
        rempty_q     <= rempty_d;
        read_en_q    <= read_en_d;
    end

    assign rempty     = rempty_q;
    assign read_en    = read_en_q;
    assign raddr      = raddr_q;
    assign raddr_gray = raddr_gray_q;

`ifdef FIFO_READ_OCCUPANCY_EN
    logic [PTR_SZ:0]   occ_diff_s;
    logic [PTR_SZ-1:0] rcount_q, rcount_d;

    // Modular occupancy. Add DEPTH back when the write pointer has wrapped
    // behind the read pointer.
    always_comb begin
        occ_diff_s = {1'b0, wbin_s} - {1'b0, raddr_q};
        if (wbin_s >= raddr_q) begin
            occ_diff_s = {1'b0, wbin_s} - {1'b0, raddr_q};
        end else begin
            occ_diff_s = {1'b0, wbin_s} + (PTR_SZ+1)'(DEPTH) - {1'b0, raddr_q};
        end
        if (rst) begin
            rcount_d = {PTR_SZ{1'b0}};
        end else begin
            rcount_d = occ_diff_s[PTR_SZ-1:0];
        end
    end

    // Occupancy register, one cycle behind its inputs.
    always_ff @(posedge clk) begin
        rcount_q <= rcount_d;
    end

    assign rcount = rcount_q;
`endif

endmodule

// File: tb/tb_fifo_read_logic.sv
module tb_fifo_read_logic;

    logic       clk;
    logic       rst;
    logic       rinc;
    logic [1:0] rq2_waddr;
    logic       rempty;
    logic       read_en;
    logic [1:0] raddr;
    logic [1:0] raddr_gray;
`ifdef FIFO_READ_OCCUPANCY_EN
    logic [1:0] rcount;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_read_logic #(
        .DEPTH  (3),
        .PTR_SZ (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rinc       (rinc),
        .rq2_waddr  (rq2_waddr),
        .rempty     (rempty),
        .read_en    (read_en),
        .raddr      (raddr),
        .raddr_gray (raddr_gray)
`ifdef FIFO_READ_OCCUPANCY_EN
        ,
        .rcount     (rcount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all main outputs at once.
    task automatic chk_all(input string tag, input logic e_empty, input logic e_ren,
                           input logic [1:0] e_addr, input logic [1:0] e_gray);
        chk({tag, ".rempty"},     8'(rempty),     8'(e_empty));
        chk({tag, ".read_en"},    8'(read_en),    8'(e_ren));
        chk({tag, ".raddr"},      8'(raddr),      8'(e_addr));
        chk({tag, ".raddr_gray"}, 8'(raddr_gray), 8'(e_gray));
    endtask

    initial begin
        rst       = 1'b1;
        rinc      = 1'b0;
        rq2_waddr = 2'b11;

        // Reset for two edges with a non-zero write pointer.
        step();
        step();
        chk_all("reset", 1'b1, 1'b0, 2'd0, 2'b00);
`ifdef FIFO_READ_OCCUPANCY_EN
        chk("reset.rcount", 8'(rcount), 8'd0);
`endif

        // Single read: write pointer Gray 01 means binary 1.
        rst       = 1'b0;
        rq2_waddr = 2'b00;
        step();
        chk_all("idle_empty", 1'b1, 1'b0, 2'd0, 2'b00);
        rq2_waddr = 2'b01;
        step();
        chk_all("single_avail", 1'b0, 1'b0, 2'd0, 2'b00);
        rinc = 1'b1;
        step();
        chk_all("single_read", 1'b0, 1'b1, 2'd0, 2'b00);
        rinc = 1'b0;
        step();
        chk_all("single_done", 1'b1, 1'b0, 2'd1, 2'b01);

        // Burst: reset with wbin 2 (Gray 11), then hold rinc.
        rst       = 1'b1;
        rq2_waddr = 2'b11;
        step();
        chk_all("burst_rst", 1'b1, 1'b0, 2'd0, 2'b00);
        rst = 1'b0;
        step();
        chk_all("burst_avail", 1'b0, 1'b0, 2'd0, 2'b00);
`ifdef FIFO_READ_OCCUPANCY_EN
        chk("occ.two", 8'(rcount), 8'd2);
`endif
        rinc = 1'b1;
        step();
        chk_all("burst_rd0", 1'b0, 1'b1, 2'd0, 2'b00);
        step();
        chk_all("burst_rd1", 1'b0, 1'b1, 2'd1, 2'b01);
        step();
        chk_all("burst_done", 1'b1, 1'b0, 2'd2, 2'b11);
`ifdef FIFO_READ_OCCUPANCY_EN
        chk("occ.one", 8'(rcount), 8'd1);
`endif

        // Wrap: wbin 0 (Gray 00), rinc still held.
        rq2_waddr = 2'b00;
        step();
        chk_all("wrap_avail", 1'b0, 1'b0, 2'd2, 2'b11);
        step();
        chk_all("wrap_read", 1'b0, 1'b1, 2'd2, 2'b11);
        step();
        chk_all("wrap_done", 1'b1, 1'b0, 2'd0, 2'b00);

        // rinc while empty is ignored.
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("empty_rinc", 1'b1, 1'b0, 2'd0, 2'b00);
        end
        rinc = 1'b0;

        // Simultaneous write during the last read, rinc low: continue to AVAIL.
        rq2_waddr = 2'b01;
        step();
        chk_all("sim_avail", 1'b0, 1'b0, 2'd0, 2'b00);
        rinc = 1'b1;
        step();
        chk_all("sim_read", 1'b0, 1'b1, 2'd0, 2'b00);
        rinc      = 1'b0;
        rq2_waddr = 2'b11;
        step();
        chk_all("sim_to_avail", 1'b0, 1'b0, 2'd1, 2'b01);

        // Same race with rinc high: back-to-back read.
        rinc = 1'b1;
        step();
        chk_all("sim2_read", 1'b0, 1'b1, 2'd1, 2'b01);
        rq2_waddr = 2'b00;
        step();
        chk_all("sim2_to_read", 1'b0, 1'b1, 2'd2, 2'b11);
        rinc = 1'b0;
        step();
        chk_all("sim2_done", 1'b1, 1'b0, 2'd0, 2'b00);

        // Reset in the middle of a read aborts it.
        rq2_waddr = 2'b01;
        step();
        rinc = 1'b1;
        step();
        chk_all("mid_read", 1'b0, 1'b1, 2'd0, 2'b00);
        rst = 1'b1;
        step();
        chk_all("mid_rst", 1'b1, 1'b0, 2'd0, 2'b00);
`ifdef FIFO_READ_OCCUPANCY_EN
        chk("occ.rst", 8'(rcount), 8'd0);
`endif
        rst  = 1'b0;
        rinc = 1'b0;
        step();
        chk_all("post_rst", 1'b0, 1'b0, 2'd0, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
